// File: rtl/csr_trap_seq.sv
// CSR/trap sequencer: one CSRRW/RS/RC, ECALL or MRET at a time via read, modify and write steps.
// Define CSR_TRAP_SEQ_MSTATUS_EN to add the RD2 mstatus read and the mstatus update on ECALL/MRET.
module csr_trap_seq #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [1:0]            req_csr,
   input  logic [DATA_WIDTH-1:0] req_src,
   input  logic [4:0]            req_rd,
   input  logic [DATA_WIDTH-1:0] req_pc,
   output logic [1:0]            c_raddr,
   input  logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  c_wen,
   output logic [1:0]            c_waddr,
   output logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_wen1_2,
   output logic [1:0]            c_waddr1,
   output logic [DATA_WIDTH-1:0] c_wdata1,
   output logic [1:0]            c_waddr2,
   output logic [DATA_WIDTH-1:0] c_wdata2,
   output logic                  gpr_wen,
   output logic [4:0]            gpr_waddr,
   output logic [DATA_WIDTH-1:0] gpr_wdata,
   output logic                  done,
   output logic                  err,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc
);

   localparam logic [2:0] OpRw    = 3'd0;
   localparam logic [2:0] OpRs    = 3'd1;
   localparam logic [2:0] OpRc    = 3'd2;
   localparam logic [2:0] OpEcall = 3'd3;
   localparam logic [2:0] OpMret  = 3'd4;

   localparam logic [1:0] CsrMstatus = 2'd0;
   localparam logic [1:0] CsrMtvec   = 2'd1;
   localparam logic [1:0] CsrMepc    = 2'd2;
   localparam logic [1:0] CsrMcause  = 2'd3;

   localparam logic [DATA_WIDTH-1:0] CauseEcallM = DATA_WIDTH'(11);

`ifdef CSR_TRAP_SEQ_MSTATUS_EN
   typedef enum logic [1:0] {StIdle, StRd, StRd2, StWb} state_e;
`else
   typedef enum logic [1:0] {StIdle, StRd, StWb} state_e;
`endif

   state_e state_q, state_d;

   logic [2:0]            op_q;
   logic [1:0]            csr_q;
   logic [DATA_WIDTH-1:0] src_q;
   logic [4:0]            rd_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] old_q;

   logic is_csrrx, is_ecall, is_mret;
   logic [DATA_WIDTH-1:0] csr_mod;

   assign is_csrrx = (op_q == OpRw) || (op_q == OpRs) || (op_q == OpRc);
   assign is_ecall = (op_q == OpEcall);
   assign is_mret  = (op_q == OpMret);

`ifdef CSR_TRAP_SEQ_MSTATUS_EN
   logic [DATA_WIDTH-1:0] ms_q;
   logic [DATA_WIDTH-1:0] ms_ecall, ms_mret;

   // Trap entry stacks MIE into MPIE and records M-mode as previous privilege.
   always_comb begin
      ms_ecall        = ms_q;
      ms_ecall[7]     = ms_q[3];
      ms_ecall[3]     = 1'b0;
      ms_ecall[12:11] = 2'b11;
      ms_mret         = ms_q;
      ms_mret[3]      = ms_q[7];
      ms_mret[7]      = 1'b1;
      ms_mret[12:11]  = 2'b00;
   end
`endif

   always_comb begin
      unique case (op_q)
         OpRs:    csr_mod = old_q | src_q;
         OpRc:    csr_mod = old_q & ~src_q;
         default: csr_mod = src_q;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latch and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= '0;
         csr_q <= '0;
         src_q <= '0;
         rd_q  <= '0;
         pc_q  <= '0;
         old_q <= '0;
      end else begin
         if (state_q == StIdle && req_valid) begin
            op_q  <= req_op;
            csr_q <= req_csr;
            src_q <= req_src;
            rd_q  <= req_rd;
            pc_q  <= req_pc;
         end
         if (state_q == StRd && (is_csrrx || is_ecall || is_mret)) begin
            old_q <= c_rdata;
         end
      end
   end

`ifdef CSR_TRAP_SEQ_MSTATUS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ms_q <= '0;
      end else if (state_q == StRd2) begin
         ms_q <= c_rdata;
      end
   end
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) state_d = StRd;
         end
`ifdef CSR_TRAP_SEQ_MSTATUS_EN
         StRd: begin
            if (is_ecall || is_mret) state_d = StRd2;
            else                     state_d = StWb;
         end
         StRd2: state_d = StWb;
`else
         StRd: state_d = StWb;
`endif
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic; everything held at zero while rst is asserted
   always_comb begin
      req_ready      = 1'b0;
      c_raddr        = '0;
      c_wen          = 1'b0;
      c_waddr        = '0;
      c_wdata        = '0;
      c_wen1_2       = 1'b0;
      c_waddr1       = '0;
      c_wdata1       = '0;
      c_waddr2       = '0;
      c_wdata2       = '0;
      gpr_wen        = 1'b0;
      gpr_waddr      = '0;
      gpr_wdata      = '0;
      done           = 1'b0;
      err            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (!rst) begin
         unique case (state_q)
            StIdle: req_ready = 1'b1;
            StRd: begin
               if (is_csrrx)      c_raddr = csr_q;
               else if (is_ecall) c_raddr = CsrMtvec;
               else if (is_mret)  c_raddr = CsrMepc;
            end
`ifdef CSR_TRAP_SEQ_MSTATUS_EN
            StRd2: c_raddr = CsrMstatus;
`endif
            StWb: begin
               done = 1'b1;
               if (is_csrrx) begin
                  c_wen     = 1'b1;
                  c_waddr   = csr_q;
                  c_wdata   = csr_mod;
                  gpr_wen   = (rd_q != 5'd0);
                  gpr_waddr = rd_q;
                  gpr_wdata = old_q;
               end else if (is_ecall) begin
                  c_wen1_2       = 1'b1;
                  c_waddr1       = CsrMepc;
                  c_wdata1       = pc_q;
                  c_waddr2       = CsrMcause;
                  c_wdata2       = CauseEcallM;
`ifdef CSR_TRAP_SEQ_MSTATUS_EN
                  c_wen          = 1'b1;
                  c_waddr        = CsrMstatus;
                  c_wdata        = ms_ecall;
`endif
                  redirect_valid = 1'b1;
                  redirect_pc    = old_q;
               end else if (is_mret) begin
`ifdef CSR_TRAP_SEQ_MSTATUS_EN
                  c_wen          = 1'b1;
                  c_waddr        = CsrMstatus;
                  c_wdata        = ms_mret;
`endif
                  redirect_valid = 1'b1;
                  redirect_pc    = old_q;
               end else begin
                  err = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Randomized bench for csr_trap_seq: a behavioural CSR-bank model predicts every transaction.
// Honours CSR_TRAP_SEQ_MSTATUS_EN in the same way as the design.
module tb_csr_trap_seq;

   localparam int unsigned DW = 64;
`ifdef CSR_TRAP_SEQ_MSTATUS_EN
   localparam bit MsEn = 1'b1;
`else
   localparam bit MsEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [1:0]    req_csr;
   logic [DW-1:0] req_src;
   logic [4:0]    req_rd;
   logic [DW-1:0] req_pc;
   logic [1:0]    c_raddr;
   logic [DW-1:0] c_rdata;
   logic          c_wen;
   logic [1:0]    c_waddr;
   logic [DW-1:0] c_wdata;
   logic          c_wen1_2;
   logic [1:0]    c_waddr1;
   logic [DW-1:0] c_wdata1;
   logic [1:0]    c_waddr2;
   logic [DW-1:0] c_wdata2;
   logic          gpr_wen;
   logic [4:0]    gpr_waddr;
   logic [DW-1:0] gpr_wdata;
   logic          done;
   logic          err;
   logic          redirect_valid;
   logic [DW-1:0] redirect_pc;

   csr_trap_seq #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
      .req_src(req_src), .req_rd(req_rd), .req_pc(req_pc),
      .c_raddr(c_raddr), .c_rdata(c_rdata),
      .c_wen(c_wen), .c_waddr(c_waddr), .c_wdata(c_wdata),
      .c_wen1_2(c_wen1_2), .c_waddr1(c_waddr1), .c_wdata1(c_wdata1),
      .c_waddr2(c_waddr2), .c_wdata2(c_wdata2),
      .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .done(done), .err(err), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   // CSR bank driven by the DUT write ports, preloadable while idle
   logic [DW-1:0] bank [4];
   logic          load_en = 1'b0;
   logic [DW-1:0] load_val [4];
   assign c_rdata = bank[c_raddr];

   int            gpr_cnt = 0;
   logic [4:0]    gpr_last_addr = '0;
   logic [DW-1:0] gpr_last_data = '0;
   int            done_cnt = 0;
   int            stray_cnt = 0;
   int            clash_cnt = 0;

   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 4; i++) bank[i] <= load_val[i];
      end else begin
         if (c_wen) bank[c_waddr] <= c_wdata;
         if (c_wen1_2) begin
            bank[c_waddr1] <= c_wdata1;
            bank[c_waddr2] <= c_wdata2;
         end
      end
      if (gpr_wen) begin
         gpr_cnt       <= gpr_cnt + 1;
         gpr_last_addr <= gpr_waddr;
         gpr_last_data <= gpr_wdata;
      end
      if (done) done_cnt <= done_cnt + 1;
      if ((c_wen || c_wen1_2 || gpr_wen || err || redirect_valid) && !done)
         stray_cnt <= stray_cnt + 1;
      if (c_wen && c_wen1_2 && (c_waddr == c_waddr1 || c_waddr == c_waddr2))
         clash_cnt <= clash_cnt + 1;
   end

   int vec = 0;
   int bad = 0;
   logic [DW-1:0] m [4];

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vec++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                          input logic [DW-1:0] v2, input logic [DW-1:0] v3);
      load_val[0] = v0; load_val[1] = v1; load_val[2] = v2; load_val[3] = v3;
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      m[0] = v0; m[1] = v1; m[2] = v2; m[3] = v3;
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_csr%0d", tag, i), bank[i], m[i]);
   endtask

   // Issue one request from idle, predict its effects, and check them once it completes.
   task automatic run(input logic [2:0] op, input logic [1:0] csr, input logic [DW-1:0] src,
                      input logic [4:0] rd, input logic [DW-1:0] pc, input bit hold);
      logic [DW-1:0] old, ms, exp_redir;
      bit            exp_rv, exp_err, exp_gpr, found;
      int            lat, n, g0, d0;
      chk("ready_before", {63'd0, req_ready}, 1);
      req_valid = 1'b1; req_op = op; req_csr = csr; req_src = src; req_rd = rd; req_pc = pc;
      g0 = gpr_cnt; d0 = done_cnt;
      exp_rv = 0; exp_err = 0; exp_gpr = 0; exp_redir = '0; lat = 2;
      ms = m[0];
      if (op <= 3'd2) begin
         old = m[csr];
         if (op == 3'd0)      m[csr] = src;
         else if (op == 3'd1) m[csr] = old | src;
         else                 m[csr] = old & ~src;
         exp_gpr = (rd != 0);
      end else if (op == 3'd3) begin
         old = m[1];
         exp_rv = 1; exp_redir = old;
         m[2] = pc; m[3] = 64'd11;
         if (MsEn) begin
            lat = 3;
            m[0] = ms; m[0][7] = ms[3]; m[0][3] = 1'b0; m[0][12:11] = 2'b11;
         end
      end else if (op == 3'd4) begin
         old = m[2];
         exp_rv = 1; exp_redir = old;
         if (MsEn) begin
            lat = 3;
            m[0] = ms; m[0][3] = ms[7]; m[0][7] = 1'b1; m[0][12:11] = 2'b00;
         end
      end else begin
         old = '0;
         exp_err = 1;
      end
      @(negedge clk);
      if (hold) begin
         req_op = 3'd0; req_csr = 2'd0; req_src = '1; req_rd = 5'd1;
      end else begin
         req_valid = 1'b0;
      end
      n = 1; found = 0;
      while (n <= 8 && !found) begin
         if (done) found = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("done_latency", n, lat);
      if (found) begin
         chk("err", {63'd0, err}, {63'd0, exp_err});
         chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, exp_rv});
         if (exp_rv) chk("redirect_pc", redirect_pc, exp_redir);
         chk("ready_busy", {63'd0, req_ready}, 0);
      end
      req_valid = 1'b0;
      @(negedge clk);
      check_bank("wb");
      chk("gpr_count", gpr_cnt - g0, exp_gpr ? 1 : 0);
      if (exp_gpr) begin
         chk("gpr_addr", {59'd0, gpr_last_addr}, {59'd0, rd});
         chk("gpr_data", gpr_last_data, old);
      end
      chk("done_count", done_cnt - d0, 1);
   endtask

   initial begin
      int g0, d0;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_csr = '0; req_src = '0; req_rd = '0;
      req_pc = '0;
      for (int i = 0; i < 4; i++) load_val[i] = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {63'd0, req_ready}, 0);
      chk("rst_done", {63'd0, done}, 0);
      chk("rst_raddr", {62'd0, c_raddr}, 0);
      preload(64'h8, 64'h100, 64'h0, 64'hF0);
      rst = 1'b0;
      @(negedge clk);

      // CSRRW mtvec, old value to x5
      run(3'd0, 2'd1, 64'h8000_0000, 5'd5, 64'h0, 0);
      chk("tp_mtvec", bank[1], 64'h8000_0000);
      chk("tp_x5", gpr_last_data, 64'h100);
      // CSRRC mcause with rd=0
      run(3'd2, 2'd3, 64'h30, 5'd0, 64'h0, 0);
      chk("tp_mcause", bank[3], 64'hC0);
      // ECALL
      preload(64'h8, 64'h8000_1000, 64'h0, 64'h0);
      run(3'd3, 2'd0, 64'h0, 5'd0, 64'h8000_0040, 0);
      chk("tp_mepc", bank[2], 64'h8000_0040);
      chk("tp_mcause11", bank[3], 64'd11);
      chk("tp_ecall_ms", bank[0], MsEn ? 64'h1880 : 64'h8);
      // MRET
      preload(64'h1880, 64'h0, 64'h8000_0044, 64'h0);
      run(3'd4, 2'd0, 64'h0, 5'd0, 64'h0, 0);
      chk("tp_mret_ms", bank[0], MsEn ? 64'h88 : 64'h1880);
      // Illegal op with a second request held through the whole sequence
      run(3'd6, 2'd2, 64'h55, 5'd7, 64'h0, 1);
      run(3'd1, 2'd0, 64'h0, 5'd9, 64'h0, 0);

      // Reset in the cycle after RD of an ECALL (RD2 when the mstatus path is built)
      preload(64'h8, 64'h8000_1000, 64'h1234, 64'h5);
      g0 = gpr_cnt; d0 = done_cnt;
      req_valid = 1'b1; req_op = 3'd3; req_pc = 64'hDEAD_0000;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_done", {63'd0, done}, 0);
      chk("mid_rst_ready", {63'd0, req_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {63'd0, req_ready}, 1);
      check_bank("mid_rst");
      chk("mid_rst_gpr", gpr_cnt - g0, 0);
      chk("mid_rst_donecnt", done_cnt - d0, 0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 4) == 0)
            preload({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom});
         run(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
             5'($urandom_range(0, 31)), {$urandom, $urandom}, bit'($urandom_range(0, 1)));
      end

      chk("stray_strobes", stray_cnt, 0);
      chk("write_clash", clash_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
